// File: rtl/multiplier_datapath.sv
// Shift-add multiplier datapath: operand registers, adder and product shifter; results visible 1 cycle after a strobe.
// No backpressure, one step per strobed cycle; DP_STEP_COUNT_EN adds the step_cnt/step_done outputs.
module multiplier_datapath #(
  parameter int          WIDTH     = 32,
  parameter logic [5:0]  ADDU_CODE = 6'b001001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic [WIDTH-1:0]     multiplier_in,
  input  logic                 w_ctrl_Multiplicand,
  input  logic                 adding_ctrl,
  input  logic [5:0]           addu_ctrl,
  input  logic                 w_ctrl_Product,
  output logic                 lsb,
`ifdef DP_STEP_COUNT_EN
  output logic [5:0]           step_cnt,
  output logic                 step_done,
`endif
  output logic [2*WIDTH-1:0]   product
);

  logic [WIDTH-1:0]   multiplicand_q;
  logic [2*WIDTH-1:0] product_q;
  logic               add_en;
  logic               step_en;
  logic [WIDTH:0]     sum_w;
  logic [2*WIDTH-1:0] shift_w;

  // A load in the same cycle as a step wins; the step is dropped.
  assign step_en = w_ctrl_Product && !w_ctrl_Multiplicand;

  always_comb begin
    add_en  = adding_ctrl && (addu_ctrl == ADDU_CODE);
    sum_w   = {1'b0, product_q[2*WIDTH-1:WIDTH]} + {1'b0, multiplicand_q};
    // The carry lands in the top bit as the whole register shifts right.
    shift_w = add_en ? {sum_w, product_q[WIDTH-1:1]}
                     : {1'b0, product_q[2*WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      multiplicand_q <= '0;
      product_q      <= '0;
    end else if (w_ctrl_Multiplicand) begin
      multiplicand_q <= multiplicand_in;
      product_q      <= {{WIDTH{1'b0}}, multiplier_in};
    end else if (step_en) begin
      product_q      <= shift_w;
    end
  end

  assign product = product_q;
  assign lsb     = product_q[0];

`ifdef DP_STEP_COUNT_EN
  localparam logic [5:0] CNT_MAX = 6'(WIDTH);

  logic [5:0] cnt_q;
  logic [5:0] cnt_nxt;
  logic       done_q;

  always_comb begin
    cnt_nxt = cnt_q;
    if (w_ctrl_Multiplicand) begin
      cnt_nxt = '0;
    end else if (step_en && (cnt_q != CNT_MAX)) begin
      cnt_nxt = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      done_q <= (cnt_nxt == CNT_MAX);
    end
  end

  assign step_cnt  = cnt_q;
  assign step_done = done_q;
`endif

endmodule

// File: tb/tb_multiplier_datapath.sv
// Directed plus randomized checks of multiplier_datapath against an arithmetic reference model.
module tb_multiplier_datapath;
  localparam int         W    = 32;
  localparam logic [5:0] ADDU = 6'b001001;

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      multiplicand_in;
  logic [W-1:0]      multiplier_in;
  logic              w_ctrl_Multiplicand;
  logic              adding_ctrl;
  logic [5:0]        addu_ctrl;
  logic              w_ctrl_Product;
  logic              lsb;
  logic [2*W-1:0]    product;
`ifdef DP_STEP_COUNT_EN
  logic [5:0]        step_cnt;
  logic              step_done;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: operand A and the 2W-bit product register value.
  logic [W-1:0]   m_a;
  logic [2*W-1:0] m_p;
  int             m_cnt;

  always #5 clk = ~clk;

  multiplier_datapath #(.WIDTH(W), .ADDU_CODE(ADDU)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .multiplicand_in     (multiplicand_in),
    .multiplier_in       (multiplier_in),
    .w_ctrl_Multiplicand (w_ctrl_Multiplicand),
    .adding_ctrl         (adding_ctrl),
    .addu_ctrl           (addu_ctrl),
    .w_ctrl_Product      (w_ctrl_Product),
    .lsb                 (lsb),
`ifdef DP_STEP_COUNT_EN
    .step_cnt            (step_cnt),
    .step_done           (step_done),
`endif
    .product             (product)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_product"}, product, m_p);
    chk({tag, "_lsb"}, 64'(lsb), 64'(m_p[0]));
`ifdef DP_STEP_COUNT_EN
    chk({tag, "_cnt"}, 64'(step_cnt), 64'(m_cnt));
    chk({tag, "_done"}, 64'(step_done), 64'(m_cnt == W));
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    w_ctrl_Multiplicand = 1'b0;
    w_ctrl_Product      = 1'b0;
    adding_ctrl         = 1'b0;
    addu_ctrl           = 6'd0;
    chk_state(tag);
  endtask

  function automatic void model_step(input logic add, input logic [5:0] code);
    logic [2*W:0] wide;
    if (add && code == ADDU) begin
      wide = {1'b0, m_p} + ({{(W+1){1'b0}}, m_a} << W);
      m_p  = wide[2*W:1];
    end else begin
      m_p = m_p >> 1;
    end
    if (m_cnt < W) m_cnt++;
  endfunction

  task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    multiplicand_in     = a;
    multiplier_in       = b;
    w_ctrl_Multiplicand = 1'b1;
    m_a   = a;
    m_p   = {{W{1'b0}}, b};
    m_cnt = 0;
    tick(tag);
  endtask

  task automatic do_step(input logic add, input logic [5:0] code, input string tag);
    w_ctrl_Product = 1'b1;
    adding_ctrl    = add;
    addu_ctrl      = code;
    model_step(add, code);
    tick(tag);
  endtask

  // Behaves like the controller: add whenever the current product LSB is set.
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    do_load(a, b, {tag, "_load"});
    for (int i = 0; i < W; i++) do_step(m_p[0], ADDU, tag);
    chk({tag, "_final"}, product, 64'(a) * 64'(b));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst = 1'b0;
    multiplicand_in = '0; multiplier_in = '0;
    w_ctrl_Multiplicand = 1'b0; w_ctrl_Product = 1'b0;
    adding_ctrl = 1'b0; addu_ctrl = 6'd0;
    m_a = '0; m_p = '0; m_cnt = 0;
    #12;
    chk_state("reset");
    rst = 1'b1;
    #10;

    // 1, 2: directed products
    run_mult(32'd3, 32'd5, "t1");
    chk("t1_const", product, 64'd15);
    run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, "t2");
    chk("t2_const", product, 64'hFFFFFFFE00000001);

    // 3: adding_ctrl with a non-ADDU code is a plain shift
    do_load(32'd7, 32'd1, "t3_load");
    chk("t3_lsb_after_load", 64'(lsb), 64'd1);
    do_step(1'b1, 6'b000000, "t3_step");
    chk("t3_const", product, 64'h0);

    // 4: simultaneous load and step, load wins
    do_load(32'd9, 32'd6, "t4_load");
    multiplicand_in = 32'd2; multiplier_in = 32'd3;
    w_ctrl_Multiplicand = 1'b1; w_ctrl_Product = 1'b1;
    adding_ctrl = 1'b1; addu_ctrl = ADDU;
    m_a = 32'd2; m_p = 64'd3; m_cnt = 0;
    tick("t4_both");
    chk("t4_const", product, 64'h3);
    for (int i = 0; i < W; i++) do_step(m_p[0], ADDU, "t4_run");
    chk("t4_final", product, 64'd6);

    // Idle cycles: operand inputs wiggle but nothing is strobed
    for (int i = 0; i < 4; i++) begin
      multiplicand_in = $urandom; multiplier_in = $urandom;
      adding_ctrl = 1'b1; addu_ctrl = ADDU;
      tick("idle");
    end

    // 5: asynchronous reset mid-multiply
    do_load(32'd5, 32'd5, "t5_load");
    for (int i = 0; i < 10; i++) do_step(m_p[0], ADDU, "t5_run");
    #2;
    rst = 1'b0;
    #1;
    m_a = '0; m_p = '0; m_cnt = 0;
    chk_state("t5_in_reset");
    #2;
    rst = 1'b1;
    // A step right after reset: multiplicand must also be cleared, so adding changes nothing.
    do_step(1'b1, ADDU, "t5_post_rst_step");
    run_mult(32'd5, 32'd5, "t5_fresh");
    chk("t5_const", product, 64'd25);

    // Random operands driven like the controller
    for (int r = 0; r < 8; r++) begin
      ra = $urandom; rb = $urandom;
      if (r == 0) ra = '0;
      if (r == 1) rb = 32'h80000001;
      run_mult(ra, rb, "rand_mult");
    end

    // Random strobe patterns, including non-ADDU codes and steps past WIDTH
    for (int r = 0; r < 4; r++) begin
      do_load($urandom, $urandom, "rand_load");
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 3) == 0) tick("rand_idle");
        else do_step(1'($urandom), ($urandom_range(0, 1) == 1) ? ADDU : 6'($urandom), "rand_step");
      end
    end

`ifdef DP_STEP_COUNT_EN
    // 6: step counter saturation and clear on load
    do_load(32'd11, 32'd13, "t6_load");
    for (int i = 0; i < 40; i++) begin
      do_step(m_p[0], ADDU, "t6_step");
      if (i == W - 1) begin
        chk("t6_cnt32", 64'(step_cnt), 64'd32);
        chk("t6_done32", 64'(step_done), 64'd1);
      end
    end
    chk("t6_cnt_sat", 64'(step_cnt), 64'd32);
    do_load(32'd1, 32'd1, "t6_reload");
    chk("t6_cnt_clr", 64'(step_cnt), 64'd0);
    chk("t6_done_clr", 64'(step_done), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
